// File: rtl/ysyx_24110015_mem_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_pkg
// Shared types for the IFU/LSU SRAM arbiter.
//   owner_t   : which requester owns a transaction (OWN_IFU=0, OWN_LSU=1)
//   state_t   : arbiter FSM states (ST_IDLE, ST_WAIT)
//   cnt_width : width of the latency counter for a given SRAM latency
// ---------------------------------------------------------------------------
package ysyx_24110015_mem_pkg;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Counter must hold SRAM_LAT-1; one spare bit keeps SRAM_LAT=1 at width 1.
  function automatic int cnt_width(input int lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/ysyx_24110015_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_rr_arb2
// Combinational two-way round-robin picker.
//   req[1:0] : request lines (bit 0 = IFU, bit 1 = LSU)
//   last     : requester granted most recently
//   gnt[1:0] : one-hot grant (all zero when nothing requests)
//   gnt_id   : index of the granted requester (only meaningful when |gnt)
// ---------------------------------------------------------------------------
module ysyx_24110015_rr_arb2
  import ysyx_24110015_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt,
  output owner_t     gnt_id
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pick
      localparam owner_t ME    = (gi == 0) ? OWN_IFU : OWN_LSU;
      localparam int     OTHER = 1 - gi;
      // Win when alone, or on a tie when the other side was granted last.
      assign gnt[gi] = req[gi] & (~req[OTHER] | (last != ME));
    end
  endgenerate

  assign gnt_id = gnt[1] ? OWN_LSU : OWN_IFU;

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
// Arbitrates the single SRAM port between the IFU (read-only) and the LSU
// (read/write). One transaction is outstanding at a time; the response is a
// one-cycle pulse routed to the owner exactly SRAM_LAT cycles after grant.
//   clk, rst                     : clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*        : IFU request handshake and response
//   lsu_req_* / lsu_rsp_*        : LSU request handshake and response
//   sram_*                       : shared SRAM port (driven only on grant)
// ---------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                sram_ren,
  output logic [ADDR_W-1:0]   sram_raddr,
  output logic                sram_wen,
  output logic [ADDR_W-1:0]   sram_waddr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wmask,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int               CNT_W    = cnt_width(SRAM_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SRAM_LAT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  owner_t           owner_reg, owner_next;
  owner_t           last_reg, last_next;
  logic             is_wr_reg, is_wr_next;

  logic       rsp_fire;
  logic       can_grant;
  logic       grant;
  logic [1:0] gnt;
  owner_t     gnt_id;

  // Response cycle doubles as a grant slot so transactions can issue
  // back-to-back. Gating with rst keeps every output low during reset.
  assign rsp_fire  = (state_reg == ST_WAIT) && (cnt_reg == '0);
  assign can_grant = rst && ((state_reg == ST_IDLE) || rsp_fire);
  assign grant     = |gnt;

  ysyx_24110015_rr_arb2 u_rr (
    .req    ({lsu_req_valid, ifu_req_valid} & {2{can_grant}}),
    .last   (last_reg),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      owner_reg <= OWN_IFU;
      last_reg  <= OWN_LSU;
      is_wr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      is_wr_reg <= is_wr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    is_wr_next = is_wr_reg;

    if (state_reg == ST_WAIT) begin
      if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
      else               state_next = ST_IDLE;
    end

    if (grant) begin
      state_next = ST_WAIT;
      cnt_next   = CNT_INIT;
      owner_next = gnt_id;
      last_next  = gnt_id;
      is_wr_next = lsu_wen && (gnt_id == OWN_LSU);
    end
  end

  // Handshake, SRAM drive and response routing
  always_comb begin
    ifu_req_ready = gnt[0];
    lsu_req_ready = gnt[1];
    sram_ren      = 1'b0;
    sram_raddr    = '0;
    sram_wen      = 1'b0;
    sram_waddr    = '0;
    sram_wdata    = '0;
    sram_wmask    = '0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = '0;

    if (grant) begin
      if (gnt_id == OWN_LSU && lsu_wen) begin
        sram_wen   = 1'b1;
        sram_waddr = lsu_addr;
        sram_wdata = lsu_wdata;
        sram_wmask = lsu_wmask;
      end else begin
        sram_ren   = 1'b1;
        sram_raddr = (gnt_id == OWN_LSU) ? lsu_addr : ifu_addr;
      end
    end

    if (rsp_fire) begin
      if (owner_reg == OWN_IFU) begin
        ifu_rsp_valid = 1'b1;
        ifu_rdata     = is_wr_reg ? '0 : sram_rdata;
      end else begin
        lsu_rsp_valid = 1'b1;
        lsu_rdata     = is_wr_reg ? '0 : sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_mem_arbiter
// Directed bench for the IFU/LSU SRAM arbiter. Instance u_a uses SRAM_LAT=1,
// instance u_b uses SRAM_LAT=3; both share the same input stimulus and each
// scenario checks the instance it targets. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [31:0] sram_rdata;

  logic        a_ifu_req_ready, a_ifu_rsp_valid, a_lsu_req_ready, a_lsu_rsp_valid;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_sram_raddr, a_sram_waddr, a_sram_wdata;
  logic        a_sram_ren, a_sram_wen;
  logic [3:0]  a_sram_wmask;

  logic        b_ifu_req_ready, b_ifu_rsp_valid, b_lsu_req_ready, b_lsu_rsp_valid;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_sram_raddr, b_sram_waddr, b_sram_wdata;
  logic        b_sram_ren, b_sram_wen;
  logic [3:0]  b_sram_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(a_ifu_rsp_valid), .ifu_rdata(a_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(a_lsu_rsp_valid), .lsu_rdata(a_lsu_rdata),
    .sram_ren(a_sram_ren), .sram_raddr(a_sram_raddr), .sram_wen(a_sram_wen),
    .sram_waddr(a_sram_waddr), .sram_wdata(a_sram_wdata), .sram_wmask(a_sram_wmask),
    .sram_rdata(sram_rdata)
  );

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(b_ifu_rsp_valid), .ifu_rdata(b_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rdata(b_lsu_rdata),
    .sram_ren(b_sram_ren), .sram_raddr(b_sram_raddr), .sram_wen(b_sram_wen),
    .sram_waddr(b_sram_waddr), .sram_wdata(b_sram_wdata), .sram_wmask(b_sram_wmask),
    .sram_rdata(sram_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0; sram_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Outputs must stay low in reset even with requests pending.
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; sram_rdata = 32'hFFFF_FFFF;
    next_cycle();
    @(negedge clk);
    checks++; if ({a_ifu_req_ready, a_lsu_req_ready, a_ifu_rsp_valid, a_lsu_rsp_valid} !== 4'b0) begin errors++; $display("FAIL reset_a_ctrl: got %b want 0000", {a_ifu_req_ready, a_lsu_req_ready, a_ifu_rsp_valid, a_lsu_rsp_valid}); end
    checks++; if ({a_sram_ren, a_sram_wen, a_sram_raddr, a_sram_waddr, a_sram_wdata, a_sram_wmask, a_ifu_rdata, a_lsu_rdata} !== '0) begin errors++; $display("FAIL reset_a_data: some output nonzero"); end
    checks++; if ({b_ifu_req_ready, b_lsu_req_ready, b_sram_ren, b_ifu_rsp_valid, b_lsu_rsp_valid} !== 5'b0) begin errors++; $display("FAIL reset_b_ctrl: got %b want 00000", {b_ifu_req_ready, b_lsu_req_ready, b_sram_ren, b_ifu_rsp_valid, b_lsu_rsp_valid}); end
    $display("test_reset: outputs held low in reset");
  endtask

  task automatic test_ifu_read();
    apply_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    checks++; if (a_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL t1_ifu_ready: got %b want 1", a_ifu_req_ready); end
    checks++; if (a_sram_ren !== 1'b1 || a_sram_raddr !== 32'h8000_0000) begin errors++; $display("FAIL t1_sram_rd: ren=%b addr=%h want 1 80000000", a_sram_ren, a_sram_raddr); end
    checks++; if (a_ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_early_rsp: got %b want 0", a_ifu_rsp_valid); end
    next_cycle();
    ifu_req_valid = 1'b0; sram_rdata = 32'h0000_0413;
    @(negedge clk);
    checks++; if (a_ifu_rsp_valid !== 1'b1 || a_ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL t1_rsp: valid=%b data=%h want 1 00000413", a_ifu_rsp_valid, a_ifu_rdata); end
    checks++; if (a_sram_ren !== 1'b0 || a_lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_quiet: ren=%b lsu_rsp=%b want 0 0", a_sram_ren, a_lsu_rsp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (a_ifu_rsp_valid !== 1'b0 || a_ifu_rdata !== 32'h0) begin errors++; $display("FAIL t1_pulse_end: valid=%b data=%h want 0 0", a_ifu_rsp_valid, a_ifu_rdata); end
    $display("test_ifu_read: IFU read 80000000 -> 00000413");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b0;
    @(negedge clk);
    checks++; if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL t2_first_grant: ifu/lsu ready=%b want 10", {a_ifu_req_ready, a_lsu_req_ready}); end
    next_cycle();
    ifu_req_valid = 1'b0; sram_rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (a_ifu_rsp_valid !== 1'b1 || a_ifu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL t2_ifu_rsp: valid=%b data=%h want 1 11111111", a_ifu_rsp_valid, a_ifu_rdata); end
    checks++; if (a_lsu_req_ready !== 1'b1 || a_sram_raddr !== 32'h8000_0100) begin errors++; $display("FAIL t2_lsu_grant: ready=%b addr=%h want 1 80000100", a_lsu_req_ready, a_sram_raddr); end
    checks++; if (a_lsu_rdata !== 32'h0) begin errors++; $display("FAIL t2_nonowner_rdata: got %h want 0", a_lsu_rdata); end
    next_cycle();
    lsu_req_valid = 1'b0; sram_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (a_lsu_rsp_valid !== 1'b1 || a_lsu_rdata !== 32'h2222_2222) begin errors++; $display("FAIL t2_lsu_rsp: valid=%b data=%h want 1 22222222", a_lsu_rsp_valid, a_lsu_rdata); end
    checks++; if (a_ifu_rsp_valid !== 1'b0 || a_ifu_rdata !== 32'h0) begin errors++; $display("FAIL t2_ifu_quiet: valid=%b data=%h want 0 0", a_ifu_rsp_valid, a_ifu_rdata); end
    next_cycle();
    $display("test_back_to_back: IFU then LSU read issued on consecutive cycles");
  endtask

  // Runs from IDLE straight after test_back_to_back.
  task automatic test_lsu_write();
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    @(negedge clk);
    checks++; if (a_lsu_req_ready !== 1'b1 || a_sram_wen !== 1'b1 || a_sram_ren !== 1'b0) begin errors++; $display("FAIL t3_grant: ready=%b wen=%b ren=%b want 1 1 0", a_lsu_req_ready, a_sram_wen, a_sram_ren); end
    checks++; if (a_sram_waddr !== 32'h8000_1000 || a_sram_wdata !== 32'hDEAD_BEEF || a_sram_wmask !== 4'hF) begin errors++; $display("FAIL t3_payload: addr=%h data=%h mask=%h want 80001000 deadbeef f", a_sram_waddr, a_sram_wdata, a_sram_wmask); end
    next_cycle();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; sram_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (a_lsu_rsp_valid !== 1'b1 || a_lsu_rdata !== 32'h0) begin errors++; $display("FAIL t3_ack: valid=%b data=%h want 1 0", a_lsu_rsp_valid, a_lsu_rdata); end
    checks++; if (a_sram_wen !== 1'b0 || a_sram_wdata !== 32'h0) begin errors++; $display("FAIL t3_wen_once: wen=%b wdata=%h want 0 0", a_sram_wen, a_sram_wdata); end
    next_cycle();
    $display("test_lsu_write: write 80001000 <= deadbeef mask f acked");
  endtask

  task automatic test_round_robin();
    logic exp_ifu, prev_ifu;
    int ifu_cnt, lsu_cnt;
    apply_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b0;
    ifu_cnt = 0; lsu_cnt = 0; prev_ifu = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_ifu = (k % 2 == 0);
      sram_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      checks++; if ({a_ifu_req_ready, a_lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin errors++; $display("FAIL t4_grant%0d: ifu/lsu ready=%b want %b", k, {a_ifu_req_ready, a_lsu_req_ready}, {exp_ifu, ~exp_ifu}); end
      if (k > 0) begin
        checks++; if ({a_ifu_rsp_valid, a_lsu_rsp_valid} !== {prev_ifu, ~prev_ifu}) begin errors++; $display("FAIL t4_rsp%0d: ifu/lsu rsp=%b want %b", k, {a_ifu_rsp_valid, a_lsu_rsp_valid}, {prev_ifu, ~prev_ifu}); end
      end
      if (a_ifu_req_ready === 1'b1) ifu_cnt++;
      if (a_lsu_req_ready === 1'b1) lsu_cnt++;
      $display("test_round_robin: cycle %0d ifu_ready=%b lsu_ready=%b", k, a_ifu_req_ready, a_lsu_req_ready);
      prev_ifu = exp_ifu;
      next_cycle();
    end
    clear_inputs();
    checks++; if (ifu_cnt != 4 || lsu_cnt != 4) begin errors++; $display("FAIL t4_counts: ifu=%0d lsu=%0d want 4 4", ifu_cnt, lsu_cnt); end
    next_cycle();
  endtask

  task automatic test_latency3();
    apply_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    checks++; if (b_ifu_req_ready !== 1'b1 || b_sram_raddr !== 32'h8000_0000) begin errors++; $display("FAIL t5_ifu_grant: ready=%b addr=%h want 1 80000000", b_ifu_req_ready, b_sram_raddr); end
    next_cycle();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (b_lsu_req_ready !== 1'b0 || b_sram_ren !== 1'b0 || b_ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL t5_hold_T+%0d: lsu_ready=%b ren=%b ifu_rsp=%b want 0 0 0", k, b_lsu_req_ready, b_sram_ren, b_ifu_rsp_valid); end
      next_cycle();
    end
    sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (b_ifu_rsp_valid !== 1'b1 || b_ifu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL t5_ifu_rsp: valid=%b data=%h want 1 cafef00d", b_ifu_rsp_valid, b_ifu_rdata); end
    checks++; if (b_lsu_req_ready !== 1'b1 || b_sram_raddr !== 32'h8000_0200) begin errors++; $display("FAIL t5_lsu_grant: ready=%b addr=%h want 1 80000200", b_lsu_req_ready, b_sram_raddr); end
    next_cycle();
    lsu_req_valid = 1'b0;
    for (int k = 4; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (b_lsu_rsp_valid !== 1'b0 || b_ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL t5_early_T+%0d: lsu_rsp=%b ifu_rsp=%b want 0 0", k, b_lsu_rsp_valid, b_ifu_rsp_valid); end
      next_cycle();
    end
    sram_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (b_lsu_rsp_valid !== 1'b1 || b_lsu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL t5_lsu_rsp: valid=%b data=%h want 1 12345678", b_lsu_rsp_valid, b_lsu_rdata); end
    next_cycle();
    $display("test_latency3: IFU rsp at T+3, LSU granted T+3, LSU rsp at T+6");
  endtask

  task automatic test_reset_inflight();
    int pulses;
    apply_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    checks++; if (b_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL t6_ifu_grant: got %b want 1", b_ifu_req_ready); end
    next_cycle();
    ifu_req_valid = 1'b0; rst = 1'b0; sram_rdata = 32'h7777_7777;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rst = 1'b1;
      @(negedge clk);
      if (b_ifu_rsp_valid === 1'b1 || b_lsu_rsp_valid === 1'b1) pulses++;
      next_cycle();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL t6_no_pulse: saw %0d pulses want 0", pulses); end
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0300;
    @(negedge clk);
    checks++; if ({b_ifu_req_ready, b_lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL t6_ifu_first: ifu/lsu ready=%b want 10", {b_ifu_req_ready, b_lsu_req_ready}); end
    next_cycle();
    clear_inputs();
    $display("test_reset_inflight: dropped transaction, IFU wins after reset");
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_ifu_read();
    test_back_to_back();
    test_lsu_write();
    test_round_robin();
    test_latency3();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
Name: ysyx_24110015_mem_arbiter

Overview:
Two-requester arbiter for the single shared SRAM port. The instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) compete for the port. The arbiter grants one transaction at a time using round-robin, drives the SRAM port, counts the fixed SRAM read latency, and routes a one-cycle response pulse back to the requester that owns the transaction. It sits between the IFU/LSU and the SRAM instance in the core top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (must be a multiple of 8)
SRAM_LAT, 1, cycles from SRAM access to rdata valid; must be at least 1

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU read address
ifu_rsp_valid  out  1  one-cycle IFU response pulse
ifu_rdata  out  DATA_W  IFU read data, valid with ifu_rsp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  DATA_W/8  LSU byte mask
lsu_rsp_valid  out  1  one-cycle LSU response pulse (read data or write ack)
lsu_rdata  out  DATA_W  LSU read data
sram_ren  out  1  SRAM read enable
sram_raddr  out  ADDR_W  SRAM read address
sram_wen  out  1  SRAM write enable
sram_waddr  out  ADDR_W  SRAM write address
sram_wdata  out  DATA_W  SRAM write data
sram_wmask  out  DATA_W/8  SRAM byte mask
sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset
  - rst=0 asynchronously forces state IDLE, cnt=0, owner=IFU, last_grant=LSU (so the IFU wins the first tie).
  - While in reset, all outputs are 0.
  - An in-flight transaction is dropped and never produces a response pulse.
- States
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; cnt holds the cycles remaining.
- Grant
  - Allowed when state=IDLE, or when state=WAIT and cnt=0 (the response cycle, which gives back-to-back issue).
  - Grant decision is combinational from the req_valid inputs.
  - Only one valid requester: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - The winner's req_ready=1 for that cycle; the loser's req_ready=0.
  - req_ready is never 1 when the matching req_valid is 0.
- Grant-cycle SRAM drive
  - IFU or LSU read: sram_ren=1, sram_raddr=addr.
  - LSU write: sram_wen=1 with sram_waddr, sram_wdata, sram_wmask taken from the LSU inputs; sram_ren=0.
  - All SRAM enables are 0 in every non-grant cycle, and the data/address outputs are 0.
- On grant (registered)
  - owner<=winner, is_wr<=lsu_wen & (winner==LSU), last_grant<=winner.
  - state<=WAIT, cnt<=SRAM_LAT-1.
- WAIT
  - cnt!=0: cnt decrements by 1.
  - cnt=0: the owner's rsp_valid=1 for exactly this cycle.
  - Response data:
    - Read response: owner's rdata=sram_rdata combinationally in this cycle.
    - Write response: owner's rdata=0.
    - The non-owner's rdata is always 0.
  - Exit: next state is WAIT if a new grant occurs in this same cycle, otherwise IDLE.
- Latency and throughput
  - Response arrives exactly SRAM_LAT cycles after the grant.
  - Maximum throughput is one transaction per SRAM_LAT cycles.
- Simultaneous events and boundaries
  - A request arriving during WAIT with cnt!=0 is held off (ready=0). The requester must keep valid and payload stable until it sees ready.
  - Responses are never back-pressured; requesters must always accept the pulse.
  - Reset asserted during any state: apply the reset rule immediately; no partial pulses.

Decomposition:
- Shared package ysyx_24110015_mem_pkg:
  - owner encoding OWN_IFU=0, OWN_LSU=1
  - state encoding ST_IDLE, ST_WAIT
  - the width of cnt, sized as clog2(SRAM_LAT)+1
- Sub-module ysyx_24110015_rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot, gnt_id.
- Everything else (FSM, counter, SRAM drive, response routing) lives in the top module.

Test Plan:
1. Hold rst=0: all outputs 0. Release, then IFU read 0x80000000 granted at T; sram_ren=1, sram_raddr=0x80000000 at T. With sram_rdata=0x00000413 at T+1: ifu_rsp_valid=1 only at T+1, ifu_rdata=0x00000413.
2. After reset, IFU and LSU both valid (LSU read 0x80000100). IFU ready at T, LSU ready at T+1 (back-to-back). ifu_rsp_valid at T+1, lsu_rsp_valid at T+2; lsu_rdata follows sram_rdata.
3. LSU write 0x80001000 / 0xDEADBEEF / mask 0xF: sram_wen=1 for exactly one cycle with those values, sram_ren=0. lsu_rsp_valid at T+1 with lsu_rdata=0.
4. Both requesters continuously valid for 8 grants: grant order IFU,LSU,IFU,LSU,...; 4 grants each, one grant per cycle, never both ready together.
5. SRAM_LAT=3, IFU read at T with LSU valid from T+1: lsu_req_ready=0 at T+1 and T+2. ifu_rsp_valid at T+3 and LSU granted at T+3; lsu_rsp_valid at T+6.
6. SRAM_LAT=3, assert rst=0 at T+1 after an IFU grant at T: no rsp pulse ever. After release, both valid: IFU granted first.
